trap_controller: RTL and testbench

TRAP_CONTROLLER -- requirements
Module: trap_controller

---
 rtl/trap_controller_if.sv | 23 ++
 rtl/trap_controller.sv | 200 ++++++++++++++++++++
 tb/tb_trap_controller.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_controller_if.sv
// Fetch-redirect handshake between the trap controller and instruction fetch.
//   redirect_valid : controller -> fetch, a new PC is presented
//   redirect_pc    : controller -> fetch, target PC, stable while valid
//   redirect_ready : fetch -> controller, redirect accepted this cycle
interface trap_controller_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  modport master (
    output redirect_valid,
    output redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap controller: arbitrates exceptions, external/timer
// interrupts and MRET, sequences the CSR updates (mepc/mcause/mtval, then
// mstatus) and hands the new PC to fetch over a valid/ready redirect.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   exc_*                  synchronous exception request with cause/pc/tval
//   mret_req, int_ok       MRET retiring / instruction boundary reached
//   timeint, extint        level interrupt lines
//   debug, mstatus_*, mie_* current CSR state used for masking and stacking
//   mtvec, mepc, next_pc   trap vector, return PC, PC saved for interrupts
//   ack, busy              request accepted pulse / sequence in progress
//   redir                  fetch redirect handshake (master side)
//   *_we, *_in             CSR write strobes and write data
// All outputs are registered; each is visible the cycle after the FSM
// state that produces it, giving ack@0, SAVE@1, STATUS@2, redirect@3.
module trap_controller #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_req,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_req,
  input  logic            int_ok,
  input  logic            timeint,
  input  logic            extint,
  input  logic            debug,
  input  logic            mstatus_mie,
  input  logic            mstatus_mpie,
  input  logic            mie_mtie,
  input  logic            mie_meie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] next_pc,
  output logic            ack,
  output logic            busy,
  trap_controller_if.master redir,
  output logic            mepc_we,
  output logic [XLEN-1:0] mepc_in,
  output logic            mcause_we,
  output logic [XLEN-1:0] mcause_in,
  output logic            mtval_we,
  output logic [XLEN-1:0] mtval_in,
  output logic            mstatus_we,
  output logic            mstatus_mie_in,
  output logic            mstatus_mpie_in
);

  localparam logic [3:0]      CODE_EXT = 4'd11;
  localparam logic [3:0]      CODE_TMR = 4'd7;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_STATUS,
    S_RESTORE,
    S_REDIRECT
  } state_t;

  state_t          state_q;
  logic            ack_q;
  logic            busy_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic            mepc_we_q, mcause_we_q, mtval_we_q, mstatus_we_q;
  logic [XLEN-1:0] mepc_in_q, mcause_in_q, mtval_in_q;
  logic            mstatus_mie_in_q, mstatus_mpie_in_q;

  // Event context captured at acceptance.
  logic [XLEN-1:0] cause_q, epc_q, tval_q, target_q;

  logic            ext_pend, tmr_pend, accept, take_mret;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] cause_d, epc_d, tval_d, target_d;

  // Arbitration and trap context for the event that would be taken now.
  always_comb begin
    ext_pend  = extint  && mie_meie && mstatus_mie && int_ok && !debug;
    tmr_pend  = timeint && mie_mtie && mstatus_mie && int_ok && !debug;
    accept    = exc_req || ext_pend || tmr_pend || mret_req;
    take_mret = !exc_req && !ext_pend && !tmr_pend;
    irq_code  = ext_pend ? CODE_EXT : CODE_TMR;
    trap_base = mtvec & ALIGN_MASK;
    cause_d   = '0;
    epc_d     = '0;
    tval_d    = '0;
    target_d  = trap_base;
    if (exc_req) begin
      cause_d = {{(XLEN-4){1'b0}}, exc_cause};
      epc_d   = exc_pc & ALIGN_MASK;
      tval_d  = exc_tval;
    end else begin
      cause_d = {1'b1, {(XLEN-5){1'b0}}, irq_code};
      epc_d   = next_pc & ALIGN_MASK;
      // Vectored mode only for interrupts; modes 2/3 fall back to direct.
      if (mtvec[1:0] == 2'b01) begin
        target_d = trap_base + (XLEN'(irq_code) << 2);
      end
    end
  end

  // Sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      ack_q             <= 1'b0;
      busy_q            <= 1'b0;
      redirect_valid_q  <= 1'b0;
      redirect_pc_q     <= '0;
      mepc_we_q         <= 1'b0;
      mcause_we_q       <= 1'b0;
      mtval_we_q        <= 1'b0;
      mstatus_we_q      <= 1'b0;
      mepc_in_q         <= '0;
      mcause_in_q       <= '0;
      mtval_in_q        <= '0;
      mstatus_mie_in_q  <= 1'b0;
      mstatus_mpie_in_q <= 1'b0;
      cause_q           <= '0;
      epc_q             <= '0;
      tval_q            <= '0;
      target_q          <= '0;
    end else begin
      // Strobes are single-cycle pulses unless re-asserted below.
      ack_q        <= 1'b0;
      mepc_we_q    <= 1'b0;
      mcause_we_q  <= 1'b0;
      mtval_we_q   <= 1'b0;
      mstatus_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            ack_q    <= 1'b1;
            busy_q   <= 1'b1;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            tval_q   <= tval_d;
            target_q <= target_d;
            state_q  <= take_mret ? S_RESTORE : S_SAVE;
          end
        end
        S_SAVE: begin
          mepc_we_q   <= 1'b1;
          mcause_we_q <= 1'b1;
          mtval_we_q  <= 1'b1;
          mepc_in_q   <= epc_q;
          mcause_in_q <= cause_q;
          mtval_in_q  <= tval_q;
          state_q     <= S_STATUS;
        end
        S_STATUS: begin
          mstatus_we_q      <= 1'b1;
          mstatus_mie_in_q  <= 1'b0;
          mstatus_mpie_in_q <= mstatus_mie;
          redirect_pc_q     <= target_q;
          state_q           <= S_REDIRECT;
        end
        S_RESTORE: begin
          mstatus_we_q      <= 1'b1;
          mstatus_mie_in_q  <= mstatus_mpie;
          mstatus_mpie_in_q <= 1'b1;
          redirect_pc_q     <= mepc & ALIGN_MASK;
          state_q           <= S_REDIRECT;
        end
        S_REDIRECT: begin
          // Handshake completes on a cycle where valid is already visible.
          if (redirect_valid_q && redir.redirect_ready) begin
            redirect_valid_q <= 1'b0;
            busy_q           <= 1'b0;
            state_q          <= S_IDLE;
          end else begin
            redirect_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack                  = ack_q;
  assign busy                 = busy_q;
  assign redir.redirect_valid = redirect_valid_q;
  assign redir.redirect_pc    = redirect_pc_q;
  assign mepc_we              = mepc_we_q;
  assign mepc_in              = mepc_in_q;
  assign mcause_we            = mcause_we_q;
  assign mcause_in            = mcause_in_q;
  assign mtval_we             = mtval_we_q;
  assign mtval_in             = mtval_in_q;
  assign mstatus_we           = mstatus_we_q;
  assign mstatus_mie_in       = mstatus_mie_in_q;
  assign mstatus_mpie_in      = mstatus_mpie_in_q;

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: the driver pushes the expected
// event stream computed by a behavioural model, the monitor pops and
// compares each observed output event.
module tb_trap_controller;

  localparam int K_NONE = 0, K_EXC = 1, K_INT = 2, K_MRET = 3;
  localparam int E_ACK = 10, E_SAVE = 11, E_STATUS = 12, E_RVALID = 13, E_RDONE = 14;

  typedef struct {
    logic        exc_req;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc, exc_tval;
    logic        mret_req, int_ok, timeint, extint, debug;
    logic        mie, mpie, mtie, meie;
    logic [31:0] mtvec, mepc, next_pc;
  } stim_t;

  typedef struct {
    int          kind;
    int          off;
    logic [31:0] v0, v1, v2;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_req = 0, mret_req = 0, int_ok = 0, timeint = 0, extint = 0, debug = 0;
  logic [3:0]  exc_cause = '0;
  logic [31:0] exc_pc = '0, exc_tval = '0, mtvec = '0, mepc = '0, next_pc = '0;
  logic        mstatus_mie = 0, mstatus_mpie = 0, mie_mtie = 0, mie_meie = 0;
  logic        ack, busy, mepc_we, mcause_we, mtval_we, mstatus_we;
  logic [31:0] mepc_in, mcause_in, mtval_in;
  logic        mstatus_mie_in, mstatus_mpie_in;

  trap_controller_if #(.XLEN(32)) redir_if ();

  trap_controller #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .exc_req(exc_req), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_req(mret_req), .int_ok(int_ok), .timeint(timeint), .extint(extint),
    .debug(debug), .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
    .mie_mtie(mie_mtie), .mie_meie(mie_meie),
    .mtvec(mtvec), .mepc(mepc), .next_pc(next_pc),
    .ack(ack), .busy(busy), .redir(redir_if.master),
    .mepc_we(mepc_we), .mepc_in(mepc_in),
    .mcause_we(mcause_we), .mcause_in(mcause_in),
    .mtval_we(mtval_we), .mtval_in(mtval_in),
    .mstatus_we(mstatus_we), .mstatus_mie_in(mstatus_mie_in),
    .mstatus_mpie_in(mstatus_mpie_in)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   ready_mode = 0;   // 0 random, 1 held low, 2 held high
  ent_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       redir_if.redirect_ready = 1'b0;
      2:       redir_if.redirect_ready = 1'b1;
      default: redir_if.redirect_ready = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: which event the controller must take and its effects.
  function automatic void model(input stim_t s, output int kind,
                                output logic [31:0] cause, output logic [31:0] epc,
                                output logic [31:0] tval, output logic [31:0] tgt);
    bit          en   = s.mie && s.int_ok && !s.debug;
    bit          ext  = s.extint && s.meie && en;
    bit          tmr  = s.timeint && s.mtie && en;
    logic [31:0] base = s.mtvec & 32'hFFFF_FFFC;
    int          code;
    cause = '0; epc = '0; tval = '0; tgt = '0;
    if (s.exc_req) begin
      kind = K_EXC; cause = {28'd0, s.exc_cause};
      epc = s.exc_pc & 32'hFFFF_FFFC; tval = s.exc_tval; tgt = base;
    end else if (ext || tmr) begin
      code = ext ? 11 : 7;
      kind = K_INT; cause = 32'h8000_0000 | 32'(code);
      epc = s.next_pc & 32'hFFFF_FFFC;
      tgt = (s.mtvec % 4 == 1) ? base + 32'(4 * code) : base;
    end else if (s.mret_req) begin
      kind = K_MRET; tgt = s.mepc & 32'hFFFF_FFFC;
    end else begin
      kind = K_NONE;
    end
  endfunction

  function automatic stim_t base_stim();
    stim_t s;
    s = '{exc_req: 0, exc_cause: 0, exc_pc: 0, exc_tval: 0, mret_req: 0, int_ok: 1,
          timeint: 0, extint: 0, debug: 0, mie: 1, mpie: 0, mtie: 1, meie: 1,
          mtvec: 0, mepc: 0, next_pc: 0};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exc_req = s.exc_req; exc_cause = s.exc_cause; exc_pc = s.exc_pc; exc_tval = s.exc_tval;
    mret_req = s.mret_req; int_ok = s.int_ok; timeint = s.timeint; extint = s.extint;
    debug = s.debug; mstatus_mie = s.mie; mstatus_mpie = s.mpie;
    mie_mtie = s.mtie; mie_meie = s.meie;
    mtvec = s.mtvec; mepc = s.mepc; next_pc = s.next_pc;
  endtask

  task automatic clear_reqs();
    exc_req = 0; mret_req = 0; timeint = 0; extint = 0;
  endtask

  // Requests raised while busy must be ignored; context the sequence still
  // samples (mstatus, mepc, mtvec) stays stable.
  task automatic junk_reqs();
    exc_req = 1'($urandom_range(0, 1)); mret_req = 1'($urandom_range(0, 1));
    timeint = 1'($urandom_range(0, 1)); extint = 1'($urandom_range(0, 1));
    exc_cause = 4'($urandom); exc_pc = $urandom; exc_tval = $urandom; next_pc = $urandom;
  endtask

  task automatic push_expected(input stim_t s, input int kind, input logic [31:0] cause,
                               input logic [31:0] epc, input logic [31:0] tval,
                               input logic [31:0] tgt);
    exp_q.push_back('{E_ACK, 0, 0, 0, 0});
    if (kind == K_MRET) begin
      exp_q.push_back('{E_STATUS, 1, {31'd0, s.mpie}, 32'd1, 0});
      exp_q.push_back('{E_RVALID, 2, 0, 0, 0});
    end else begin
      exp_q.push_back('{E_SAVE, 1, epc, cause, tval});
      exp_q.push_back('{E_STATUS, 2, 32'd0, {31'd0, s.mie}, 0});
      exp_q.push_back('{E_RVALID, 3, 0, 0, 0});
    end
    exp_q.push_back('{E_RDONE, -1, tgt, 0, 0});
  endtask

  task automatic run(input stim_t s, input int stall);
    int          kind;
    logic [31:0] cause, epc, tval, tgt;
    bit          done;
    model(s, kind, cause, epc, tval, tgt);
    if (kind != K_NONE) push_expected(s, kind, cause, epc, tval, tgt);
    ready_mode = (stall > 0) ? 1 : 0;
    apply(s);
    @(posedge clk); #1;
    if (kind == K_NONE) begin
      chk("masked_no_ack", {31'd0, ack}, 32'd0);
      chk("masked_not_busy", {31'd0, busy}, 32'd0);
      clear_reqs();
      ready_mode = 0;
      return;
    end
    chk("ack", {31'd0, ack}, 32'd1);
    chk("busy_after_ack", {31'd0, busy}, 32'd1);
    clear_reqs();
    if (stall > 0) begin
      done = 0;
      for (int i = 0; i < 10 && !done; i++) begin
        if (redir_if.redirect_valid === 1'b1) done = 1;
        else begin @(posedge clk); #1; end
      end
      chk("redirect_valid_rises", {31'd0, done}, 32'd1);
      repeat (stall) begin
        @(posedge clk); #1;
        chk("stall_valid_held", {31'd0, redir_if.redirect_valid}, 32'd1);
      end
      ready_mode = 2;
    end
    done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      if (busy === 1'b0) done = 1;
      else begin
        if (stall == 0) junk_reqs();
        @(posedge clk); #1;
      end
    end
    chk("sequence_completes", {31'd0, done}, 32'd1);
    clear_reqs();
    ready_mode = 0;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"}, {31'd0, ack}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, redir_if.redirect_valid}, 32'd0);
    chk({tag, "_we"}, {28'd0, mepc_we, mcause_we, mtval_we, mstatus_we}, 32'd0);
    chk({tag, "_redirect_pc"}, redir_if.redirect_pc, 32'd0);
    chk({tag, "_mepc_in"}, mepc_in, 32'd0);
    chk({tag, "_mcause_in"}, mcause_in, 32'd0);
    chk({tag, "_mtval_in"}, mtval_in, 32'd0);
    chk({tag, "_mstatus_in"}, {30'd0, mstatus_mie_in, mstatus_mpie_in}, 32'd0);
  endtask

  // Monitor: pops the expected stream as output events appear.
  task automatic pop_expect(input int k, input int ack_cyc, output ent_t e);
    e = '{-1, -1, 0, 0, 0};
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL unexpected_event: got event %0d expected none (cycle %0d)", k, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_order", 32'(k), 32'(e.kind));
      if (e.off >= 0) chk("event_latency", 32'(cyc - ack_cyc), 32'(e.off));
    end
  endtask

  initial begin : monitor
    int   ack_cyc;
    bit   prev_valid;
    ent_t e;
    ack_cyc = 0; prev_valid = 0;
    forever begin
      @(negedge clk);
      if (ack === 1'b1) begin
        ack_cyc = cyc;
        pop_expect(E_ACK, ack_cyc, e);
      end
      if (mepc_we === 1'b1 || mcause_we === 1'b1 || mtval_we === 1'b1) begin
        pop_expect(E_SAVE, ack_cyc, e);
        chk("save_we_together", {29'd0, mepc_we, mcause_we, mtval_we}, 32'd7);
        chk("mepc_in", mepc_in, e.v0);
        chk("mcause_in", mcause_in, e.v1);
        chk("mtval_in", mtval_in, e.v2);
      end
      if (mstatus_we === 1'b1) begin
        pop_expect(E_STATUS, ack_cyc, e);
        chk("mstatus_mie_in", {31'd0, mstatus_mie_in}, e.v0);
        chk("mstatus_mpie_in", {31'd0, mstatus_mpie_in}, e.v1);
      end
      if (redir_if.redirect_valid === 1'b1 && !prev_valid)
        pop_expect(E_RVALID, ack_cyc, e);
      if (redir_if.redirect_valid === 1'b1 && redir_if.redirect_ready === 1'b1) begin
        pop_expect(E_RDONE, ack_cyc, e);
        chk("redirect_pc", redir_if.redirect_pc, e.v0);
      end else if (redir_if.redirect_valid === 1'b1 && exp_q.size() > 0 &&
                   exp_q[0].kind == E_RDONE) begin
        chk("redirect_pc_stable", redir_if.redirect_pc, exp_q[0].v0);
      end
      prev_valid = (redir_if.redirect_valid === 1'b1);
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : driver
    stim_t s;
    redir_if.redirect_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Exception into vectored mtvec: exceptions still go to base.
    s = base_stim();
    s.exc_req = 1; s.exc_cause = 4'd2; s.exc_pc = 32'h100; s.exc_tval = 32'hDEAD;
    s.mtvec = 32'h201;
    run(s, 0);

    // Vectored timer interrupt.
    s = base_stim();
    s.timeint = 1; s.mtvec = 32'h401; s.next_pc = 32'h84;
    run(s, 0);

    // Priority: exception over both interrupts, then external over timer.
    s = base_stim();
    s.exc_req = 1; s.exc_cause = 4'd5; s.exc_pc = 32'h2000; s.extint = 1; s.timeint = 1;
    s.mtvec = 32'h1001;
    run(s, 0);
    s.exc_req = 0;
    run(s, 0);

    // Masking: debug, global MIE clear, not at an instruction boundary.
    s = base_stim(); s.timeint = 1; s.debug = 1;  run(s, 0);
    s = base_stim(); s.timeint = 1; s.mie = 0;    run(s, 0);
    s = base_stim(); s.timeint = 1; s.int_ok = 0; run(s, 0);

    // MRET with fetch stalling the redirect.
    s = base_stim();
    s.mret_req = 1; s.mepc = 32'h302; s.mpie = 1; s.mie = 0;
    run(s, 5);

    // Vectored target wraps modulo 2^32; unaligned exception PC.
    s = base_stim();
    s.extint = 1; s.mtvec = 32'hFFFF_FFF1; s.next_pc = 32'h7;
    run(s, 0);
    s = base_stim();
    s.exc_req = 1; s.exc_cause = 4'hF; s.exc_pc = 32'h1003; s.mtvec = 32'h3; s.mie = 0;
    run(s, 0);

    // Reset while STATUS is next: the sequence must stop after SAVE.
    s = base_stim();
    s.exc_req = 1; s.exc_cause = 4'd3; s.exc_pc = 32'h500; s.mtvec = 32'h800;
    exp_q.push_back('{E_ACK, 0, 0, 0, 0});
    exp_q.push_back('{E_SAVE, 1, 32'h500, 32'd3, 32'd0});
    apply(s);
    @(posedge clk); #1;
    chk("abort_ack", {31'd0, ack}, 32'd1);
    clear_reqs();
    @(posedge clk); #1;
    chk("abort_save_cycle", {31'd0, mepc_we}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("abort");
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort_no_mstatus_we", {31'd0, mstatus_we}, 32'd0);
      chk("abort_idle", {31'd0, busy}, 32'd0);
    end
    chk("abort_scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      s.exc_req   = 1'($urandom_range(0, 3) == 0);
      s.exc_cause = 4'($urandom);
      s.exc_pc    = $urandom;
      s.exc_tval  = $urandom;
      s.mret_req  = 1'($urandom_range(0, 3) == 0);
      s.int_ok    = 1'($urandom_range(0, 4) != 0);
      s.timeint   = 1'($urandom_range(0, 1));
      s.extint    = 1'($urandom_range(0, 1));
      s.debug     = 1'($urandom_range(0, 5) == 0);
      s.mie       = 1'($urandom_range(0, 3) != 0);
      s.mpie      = 1'($urandom_range(0, 1));
      s.mtie      = 1'($urandom_range(0, 3) != 0);
      s.meie      = 1'($urandom_range(0, 3) != 0);
      s.mtvec     = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(0, 63)))
                                                : $urandom;
      s.mepc      = $urandom;
      s.next_pc   = $urandom;
      run(s, ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("final_idle", {31'd0, busy}, 32'd0);
    chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
